// File: rtl/fetch_stage.sv
// Instruction fetch: PC, in-order imem requests, 2-entry instruction FIFO.
// Optional FETCH_BUBBLE_CNT_EN adds a bubble_cnt port counting empty cycles.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        instr_valid,
   output logic [31:0] instruction_out,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4_out,
   output logic        id_flush
`ifdef FETCH_BUBBLE_CNT_EN
   ,
   output logic [31:0] bubble_cnt
`endif
);

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } fifo_entry_t;

   localparam logic [31:0] BOOT_PC = RESET_PC & ~32'h3;

   logic [31:0] fetch_pc;
   logic [31:0] resp_pc;
   logic [1:0]  outstanding;
   logic [1:0]  discard;
   logic [1:0]  fifo_count;
   fifo_entry_t fifo_q [2];
   logic        rd_ptr;
   logic        wr_ptr;

   logic        pop;
   logic        push;
   logic        drop;
   logic        accept;
   logic        credit;
   logic [31:0] redir_target;

   assign redir_target = redirect_pc & ~32'h3;

   always_comb begin
      pop    = instr_valid & id_ready & ~redirect_valid;
      // pop frees a slot this cycle, so it counts as credit right away
      credit = ({1'b0, outstanding} + {1'b0, fifo_count})
               < (3'd2 + {2'b00, pop});
      imem_req_valid = ~rst & ~redirect_valid & credit;
      accept = imem_req_valid & imem_req_ready;
      drop   = imem_rsp_valid & (discard != 2'd0);
      push   = imem_rsp_valid & (discard == 2'd0) & ~redirect_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= BOOT_PC;
         resp_pc     <= BOOT_PC;
         outstanding <= 2'd0;
         discard     <= 2'd0;
         fifo_count  <= 2'd0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
      end else begin
         outstanding <= outstanding + {1'b0, accept}
                        - {1'b0, imem_rsp_valid};
         if (redirect_valid) begin
            fetch_pc   <= redir_target;
            resp_pc    <= redir_target;
            // whatever is still in flight after this cycle is squashed
            discard    <= outstanding - {1'b0, imem_rsp_valid};
            fifo_count <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
         end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (drop) discard <= discard - 2'd1;
            if (push) begin
               resp_pc <= resp_pc + 32'd4;
               wr_ptr  <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr].word <= imem_rsp_data;
         fifo_q[wr_ptr].pc   <= resp_pc;
      end
   end

   assign imem_addr       = fetch_pc;
   assign instr_valid     = (fifo_count != 2'd0);
   assign instruction_out = instr_valid ? fifo_q[rd_ptr].word : 32'h0;
   assign pc_out          = instr_valid ? fifo_q[rd_ptr].pc : 32'h0;
   assign pc_plus4_out    = pc_out + 32'd4;
   assign id_flush        = ~instr_valid | redirect_valid;

`ifdef FETCH_BUBBLE_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) bubble_cnt <= 32'd0;
      else if (!instr_valid) bubble_cnt <= bubble_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order latency-configurable imem.
// Exercises bubble_cnt as well when FETCH_BUBBLE_CNT_EN is defined.
module tb_fetch_stage;

   localparam logic [31:0] K = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_ready = 1'b1;
   logic        instr_valid;
   logic [31:0] instruction_out;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4_out;
   logic        id_flush;
`ifdef FETCH_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt;
   logic [31:0] bmod = 32'h0;
   logic [31:0] b0;
`endif

   fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
      .clk(clk),
      .rst(rst),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .id_ready(id_ready),
      .instr_valid(instr_valid),
      .instruction_out(instruction_out),
      .pc_out(pc_out),
      .pc_plus4_out(pc_plus4_out),
      .id_flush(id_flush)
`ifdef FETCH_BUBBLE_CNT_EN
      ,
      .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int lat = 1;
   logic cur_rv = 1'b0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;
   req_t q[$];

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (rst) begin
         q.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = q[0].addr ^ K;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   end

   always @(negedge clk) begin
      req_t r;
      if (!rst) begin
         if (imem_rsp_valid) q.delete(0);
         if (imem_req_valid && imem_req_ready) begin
            r.addr = imem_addr;
            r.due  = cyc + lat;
            q.push_back(r);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

`ifdef FETCH_BUBBLE_CNT_EN
   always @(negedge clk) begin
      if (rst) bmod = 32'h0;
      else begin
         chk("bubble_model", bubble_cnt, bmod);
         if (!instr_valid) bmod = bmod + 32'd1;
      end
   end
`endif

   task automatic chk_out(input string tag, input logic er,
                          input logic [31:0] ea, input logic ev,
                          input logic [31:0] ep);
      logic [31:0] ei;
      ei = ev ? (ep ^ K) : 32'h0;
      chk({tag, ".req_valid"}, {31'h0, imem_req_valid}, {31'h0, er});
      chk({tag, ".addr"}, imem_addr, ea);
      chk({tag, ".instr_valid"}, {31'h0, instr_valid}, {31'h0, ev});
      chk({tag, ".pc"}, pc_out, ep);
      chk({tag, ".pc4"}, pc_plus4_out, ep + 32'd4);
      chk({tag, ".instr"}, instruction_out, ei);
      chk({tag, ".flush"}, {31'h0, id_flush}, {31'h0, ~ev | cur_rv});
   endtask

   task automatic drive(input logic idr, input logic rv,
                        input logic [31:0] rpc, input logic rdy = 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      id_ready = idr;
      redirect_valid = rv;
      redirect_pc = rpc;
      imem_req_ready = rdy;
      cur_rv = rv;
      @(negedge clk);
   endtask

   task automatic do_reset;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
         rst = 1'b1;
         id_ready = 1'b1;
         redirect_valid = 1'b0;
         redirect_pc = 32'h0;
         imem_req_ready = 1'b1;
         cur_rv = 1'b0;
         @(negedge clk);
         chk_out("reset", 1'b0, 32'h100, 1'b0, 32'h0);
      end
   endtask

   typedef struct {
      logic        idr;
      logic        rv;
      logic [31:0] rpc;
      logic        er;
      logic [31:0] ea;
      logic        ev;
      logic [31:0] ep;
   } vec_t;

   function automatic vec_t v(input logic idr, input logic rv,
                              input logic [31:0] rpc, input logic er,
                              input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep);
      vec_t x;
      x.idr = idr; x.rv = rv; x.rpc = rpc;
      x.er = er; x.ea = ea; x.ev = ev; x.ep = ep;
      return x;
   endfunction

   vec_t tbl [16];

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired");
      $fatal(1);
   end

   initial begin
      tbl[0]  = v(1, 0, 0,        1, 32'h100,  0, 32'h0);
      tbl[1]  = v(1, 0, 0,        1, 32'h104,  0, 32'h0);
      tbl[2]  = v(1, 0, 0,        1, 32'h108,  1, 32'h100);
      tbl[3]  = v(0, 0, 0,        0, 32'h10C,  1, 32'h104);
      tbl[4]  = v(0, 0, 0,        0, 32'h10C,  1, 32'h104);
      tbl[5]  = v(0, 0, 0,        0, 32'h10C,  1, 32'h104);
      tbl[6]  = v(0, 0, 0,        0, 32'h10C,  1, 32'h104);
      tbl[7]  = v(0, 0, 0,        0, 32'h10C,  1, 32'h104);
      tbl[8]  = v(1, 0, 0,        1, 32'h10C,  1, 32'h104);
      tbl[9]  = v(1, 0, 0,        1, 32'h110,  1, 32'h108);
      tbl[10] = v(1, 0, 0,        1, 32'h114,  1, 32'h10C);
      tbl[11] = v(1, 1, 32'h2003, 0, 32'h118,  1, 32'h110);
      tbl[12] = v(1, 0, 0,        1, 32'h2000, 0, 32'h0);
      tbl[13] = v(1, 0, 0,        1, 32'h2004, 0, 32'h0);
      tbl[14] = v(1, 0, 0,        1, 32'h2008, 1, 32'h2000);
      tbl[15] = v(1, 0, 0,        1, 32'h200C, 1, 32'h2004);

      lat = 1;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].idr, tbl[i].rv, tbl[i].rpc);
         chk_out($sformatf("vec%0d", i), tbl[i].er, tbl[i].ea,
                 tbl[i].ev, tbl[i].ep);
`ifdef FETCH_BUBBLE_CNT_EN
         if (i == 2) chk("bubble_first", bubble_cnt, 32'd2);
`endif
      end

      lat = 3;
      do_reset();
      drive(1, 0, 0);        chk_out("lat3_d0", 1, 32'h100, 0, 32'h0);
      drive(1, 0, 0);        chk_out("lat3_d1", 1, 32'h104, 0, 32'h0);
      drive(1, 1, 32'h2003); chk_out("lat3_rd", 0, 32'h108, 0, 32'h0);
      drive(1, 0, 0);        chk_out("lat3_d3", 0, 32'h2000, 0, 32'h0);
      drive(1, 0, 0);        chk_out("lat3_d4", 1, 32'h2000, 0, 32'h0);
      drive(1, 0, 0);        chk_out("lat3_d5", 1, 32'h2004, 0, 32'h0);
      drive(1, 0, 0);        chk_out("lat3_d6", 0, 32'h2008, 0, 32'h0);
      drive(1, 0, 0);        chk_out("lat3_d7", 0, 32'h2008, 0, 32'h0);
      drive(1, 0, 0);        chk_out("lat3_d8", 1, 32'h2008, 1, 32'h2000);
      drive(1, 0, 0);        chk_out("lat3_d9", 1, 32'h200C, 1, 32'h2004);

      lat = 1;
      do_reset();
      drive(1, 1, 32'hFFFF_FFF8);
      chk_out("wrap_d0", 0, 32'h100, 0, 32'h0);
`ifdef FETCH_BUBBLE_CNT_EN
      b0 = bubble_cnt;
`endif
      drive(1, 0, 0); chk_out("wrap_d1", 1, 32'hFFFF_FFF8, 0, 32'h0);
      drive(1, 0, 0); chk_out("wrap_d2", 1, 32'hFFFF_FFFC, 0, 32'h0);
      drive(1, 0, 0); chk_out("wrap_d3", 1, 32'h0, 1, 32'hFFFF_FFF8);
`ifdef FETCH_BUBBLE_CNT_EN
      chk("bubble_redirect", bubble_cnt - b0, 32'd3);
`endif
      drive(1, 0, 0); chk_out("wrap_d4", 1, 32'h4, 1, 32'hFFFF_FFFC);
      chk("wrap_pc4_zero", pc_plus4_out, 32'h0);
      drive(1, 0, 0); chk_out("wrap_d5", 1, 32'h8, 1, 32'h0);

      do_reset();
      drive(1, 0, 0, 1'b0); chk_out("rdy_d0", 1, 32'h100, 0, 32'h0);
      drive(1, 0, 0);       chk_out("rdy_d1", 1, 32'h100, 0, 32'h0);
      drive(1, 0, 0);       chk_out("rdy_d2", 1, 32'h104, 0, 32'h0);
      drive(1, 0, 0);       chk_out("rdy_d3", 1, 32'h108, 1, 32'h100);
      drive(1, 0, 0);       chk_out("rdy_d4", 1, 32'h10C, 1, 32'h104);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
